// File: rtl/instr_decode.sv
// ----------------------------------------------------------------------------
// instr_decode
//
// Fetch/decode stage that sits directly in front of the core datapath. Each
// 32-bit instruction word that is accepted gets registered and expanded into
// the core's discrete control lines. The stage also:
//   - squashes the SQUASH_N accepted words that follow an issued jump,
//   - stops fetching for good when a HALT word is accepted,
//   - flags illegal words (any reserved bit set), and
//   - counts issued instructions.
//
// Ports
//   CLK, RST            clock; synchronous active-high reset
//   INSTR, INSTR_VALID  instruction word from program memory and its valid flag
//   STALL               core cannot accept an instruction this cycle
//   FETCH_EN            combinational; PC/memory may advance
//   MEM_INST, ALU_INST, JMP_INST
//                       per-instruction enables, high for exactly one cycle
//   MS1..0, IRS, RS2..0, AR2..0, BS2..0, OP, IMM
//                       decoded fields; hold their value across bubbles
//   HALTED              high while in the HALT state
//   ILLEGAL             sticky illegal-word flag
//   ISSUE_CNT           issued-instruction counter, wraps at 2^CNT_W
// ----------------------------------------------------------------------------
module instr_decode #(
    parameter int SQUASH_N = 1,   // words discarded after a JMP (0..3)
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      INSTR,
    input  logic             INSTR_VALID,
    input  logic             STALL,
    output logic             FETCH_EN,
    output logic             MEM_INST,
    output logic             ALU_INST,
    output logic             JMP_INST,
    output logic             MS1,
    output logic             MS0,
    output logic             IRS,
    output logic             RS2,
    output logic             RS1,
    output logic             RS0,
    output logic             AR2,
    output logic             AR1,
    output logic             AR0,
    output logic             BS2,
    output logic             BS1,
    output logic             BS0,
    output logic [3:0]       OP,
    output logic [7:0]       IMM,
    output logic             HALTED,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] ISSUE_CNT
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_SQUASH = 2'd1;
    localparam logic [1:0] ST_HALT   = 2'd2;

    localparam logic [1:0] CLS_NOP = 2'b00;
    localparam logic [1:0] CLS_ALU = 2'b01;
    localparam logic [1:0] CLS_MOV = 2'b10;
    localparam logic [1:0] CLS_JMP = 2'b11;

    localparam logic [1:0]       SQ_INIT = 2'(SQUASH_N);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q,   state_d;
    logic [1:0]       sq_cnt_q,  sq_cnt_d;
    logic             mem_q,     mem_d;
    logic             alu_q,     alu_d;
    logic             jmp_q,     jmp_d;
    logic [1:0]       ms_q,      ms_d;
    logic             irs_q,     irs_d;
    logic [2:0]       rs_q,      rs_d;
    logic [2:0]       ar_q,      ar_d;
    logic [2:0]       bs_q,      bs_d;
    logic [3:0]       op_q,      op_d;
    logic [7:0]       imm_q,     imm_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic [3:0] w_op;
    logic [1:0] w_cls;
    logic       w_illegal;
    logic       accept;

    assign w_op      = INSTR[31:28];
    assign w_cls     = INSTR[27:26];
    assign w_illegal = |INSTR[13:8];

    assign accept   = INSTR_VALID && !STALL && (state_q != ST_HALT);
    assign FETCH_EN = (state_q != ST_HALT) && !STALL && !RST;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        sq_cnt_d  = sq_cnt_q;
        mem_d     = 1'b0;
        alu_d     = 1'b0;
        jmp_d     = 1'b0;
        ms_d      = ms_q;
        irs_d     = irs_q;
        rs_d      = rs_q;
        ar_d      = ar_q;
        bs_d      = bs_q;
        op_d      = op_q;
        imm_d     = imm_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;

        if (accept) begin
            // Reserved bits are checked even for words that get squashed.
            if (w_illegal) illegal_d = 1'b1;

            case (state_q)
                ST_RUN: begin
                    if (!w_illegal) begin
                        if (w_cls != CLS_NOP) begin
                            mem_d = (w_cls == CLS_ALU) || (w_cls == CLS_MOV);
                            alu_d = (w_cls == CLS_ALU);
                            jmp_d = (w_cls == CLS_JMP);
                            ms_d  = INSTR[25:24];
                            irs_d = INSTR[23];
                            rs_d  = INSTR[22:20];
                            ar_d  = INSTR[19:17];
                            bs_d  = INSTR[16:14];
                            op_d  = w_op;
                            imm_d = INSTR[7:0];
                            cnt_d = cnt_q + CNT_ONE;
                            if (w_cls == CLS_JMP && SQ_INIT != 2'd0) begin
                                state_d  = ST_SQUASH;
                                sq_cnt_d = SQ_INIT;
                            end
                        end else if (w_op == 4'hF) begin
                            state_d = ST_HALT;
                        end
                    end
                end
                ST_SQUASH: begin
                    // Any accepted word, JMP/HALT included, is dropped here.
                    sq_cnt_d = sq_cnt_q - 2'd1;
                    if (sq_cnt_q == 2'd1) state_d = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_RUN;
            sq_cnt_q  <= 2'd0;
            mem_q     <= 1'b0;
            alu_q     <= 1'b0;
            jmp_q     <= 1'b0;
            ms_q      <= 2'd0;
            irs_q     <= 1'b0;
            rs_q      <= 3'd0;
            ar_q      <= 3'd0;
            bs_q      <= 3'd0;
            op_q      <= 4'd0;
            imm_q     <= 8'd0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sq_cnt_q  <= sq_cnt_d;
            mem_q     <= mem_d;
            alu_q     <= alu_d;
            jmp_q     <= jmp_d;
            ms_q      <= ms_d;
            irs_q     <= irs_d;
            rs_q      <= rs_d;
            ar_q      <= ar_d;
            bs_q      <= bs_d;
            op_q      <= op_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign MEM_INST  = mem_q;
    assign ALU_INST  = alu_q;
    assign JMP_INST  = jmp_q;
    assign {MS1, MS0}      = ms_q;
    assign IRS             = irs_q;
    assign {RS2, RS1, RS0} = rs_q;
    assign {AR2, AR1, AR0} = ar_q;
    assign {BS2, BS1, BS0} = bs_q;
    assign OP        = op_q;
    assign IMM       = imm_q;
    assign HALTED    = (state_q == ST_HALT);
    assign ILLEGAL   = illegal_q;
    assign ISSUE_CNT = cnt_q;

endmodule
